// File: rtl/nw_traceback_if.sv
// Score-RAM read port and alignment-op stream between the traceback engine
// and its neighbours (score RAM upstream, alignment formatter downstream).
interface nw_traceback_if #(
    parameter int CWIDTH = 2,
    parameter int SWIDTH = 16,
    parameter int IW     = 4
);
    logic                     rd_en;
    logic [IW-1:0]            rd_row;
    logic [IW-1:0]            rd_col;
    logic signed [SWIDTH-1:0] rd_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [1:0]               out_op;
    logic [CWIDTH-1:0]        out_a;
    logic [CWIDTH-1:0]        out_b;
    logic                     out_last;

    modport master (
        output rd_en, rd_row, rd_col,
        input  rd_data,
        output out_valid, out_op, out_a, out_b, out_last,
        input  out_ready
    );

    modport slave (
        input  rd_en, rd_row, rd_col,
        output rd_data,
        input  out_valid, out_op, out_a, out_b, out_last,
        output out_ready
    );
endinterface

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the filled score matrix from (LENGTH,LENGTH)
// to (0,0) and streams one alignment op per step, last column first.
module nw_traceback #(
    parameter int LENGTH   = 10,
    parameter int CWIDTH   = 2,
    parameter int SWIDTH   = 16,
    parameter int MATCH    = 1,
    parameter int INDEL    = -1,
    parameter int MISMATCH = -1,
    parameter int IW       = $clog2(LENGTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [LENGTH*CWIDTH-1:0]   s1,
    input  logic [LENGTH*CWIDTH-1:0]   s2,
    nw_traceback_if.master             bus,
    output logic signed [SWIDTH-1:0]   final_score,
    output logic                       busy,
    output logic                       done
);
    typedef enum logic [3:0] {
        IDLE, RD_CUR, WT_CUR, RD_DIAG, WT_DIAG, RD_UP, WT_UP, EMIT, DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MATCH = 2'd0, OP_SUB = 2'd1, OP_DEL = 2'd2, OP_INS = 2'd3
    } op_t;

    localparam logic signed [SWIDTH-1:0] W_MATCH    = SWIDTH'(MATCH);
    localparam logic signed [SWIDTH-1:0] W_MISMATCH = SWIDTH'(MISMATCH);
    localparam logic signed [SWIDTH-1:0] W_INDEL    = SWIDTH'(INDEL);
    localparam logic [IW-1:0]            LEN        = IW'(LENGTH);
    localparam logic [IW-1:0]            ONE        = IW'(1);

    function automatic logic [CWIDTH-1:0] char_at(
        input logic [LENGTH*CWIDTH-1:0] str,
        input logic [IW-1:0]            idx
    );
        char_at = '0;
        for (int unsigned k = 0; k < LENGTH; k++)
            if (IW'(k + 1) == idx) char_at = str[k*CWIDTH +: CWIDTH];
    endfunction

    state_t                   r_state, w_state_d;
    logic [IW-1:0]            r_i, r_j, w_i_d, w_j_d, w_si, w_sj;
    logic signed [SWIDTH-1:0] r_cur, r_nxt, r_final, w_cur_d, w_nxt_d, w_final_d, w_scur;
    logic [LENGTH*CWIDTH-1:0] r_s1, r_s2, w_s1_d, w_s2_d;
    op_t                      r_op, w_op_d;
    logic [CWIDTH-1:0]        r_a, r_b, w_a_d, w_b_d, w_ca, w_cb;
    logic                     r_last, w_last_d;
    logic                     r_rd_en, w_rd_en_d;
    logic [IW-1:0]            r_rd_row, r_rd_col, w_rd_row_d, w_rd_col_d;
    logic                     r_out_valid, w_out_valid_d;
    logic                     r_busy, w_busy_d, r_done, w_done_d;
    logic                     w_step;
    logic signed [SWIDTH-1:0] w_diag_w;

    assign w_ca     = char_at(r_s1, r_i);
    assign w_cb     = char_at(r_s2, r_j);
    assign w_diag_w = (w_ca == w_cb) ? W_MATCH : W_MISMATCH;

    always_comb begin
        w_state_d  = r_state;
        w_i_d      = r_i;
        w_j_d      = r_j;
        w_cur_d    = r_cur;
        w_nxt_d    = r_nxt;
        w_final_d  = r_final;
        w_s1_d     = r_s1;
        w_s2_d     = r_s2;
        w_op_d     = r_op;
        w_a_d      = r_a;
        w_b_d      = r_b;
        w_last_d   = r_last;
        w_rd_row_d = r_rd_row;
        w_rd_col_d = r_rd_col;
        w_step     = 1'b0;
        w_si       = r_i;
        w_sj       = r_j;
        w_scur     = r_cur;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_s1_d     = s1;
                    w_s2_d     = s2;
                    w_i_d      = LEN;
                    w_j_d      = LEN;
                    w_rd_row_d = LEN;
                    w_rd_col_d = LEN;
                    w_state_d  = RD_CUR;
                end
            end
            RD_CUR:  w_state_d = WT_CUR;
            WT_CUR: begin
                w_cur_d   = bus.rd_data;
                w_final_d = bus.rd_data;
                w_scur    = bus.rd_data;
                w_step    = 1'b1;
            end
            RD_DIAG: w_state_d = WT_DIAG;
            WT_DIAG: begin
                if (r_cur == bus.rd_data + w_diag_w) begin
                    w_op_d    = (w_ca == w_cb) ? OP_MATCH : OP_SUB;
                    w_a_d     = w_ca;
                    w_b_d     = w_cb;
                    w_nxt_d   = bus.rd_data;
                    w_last_d  = (r_i == ONE) && (r_j == ONE);
                    w_state_d = EMIT;
                end else begin
                    w_rd_row_d = r_i - 1'b1;
                    w_rd_col_d = r_j;
                    w_state_d  = RD_UP;
                end
            end
            RD_UP:   w_state_d = WT_UP;
            WT_UP: begin
                // Anything that is neither diagonal nor up falls to left, so an
                // inconsistent matrix still shrinks j and the walk terminates.
                if (r_cur == bus.rd_data + W_INDEL) begin
                    w_op_d   = OP_DEL;
                    w_a_d    = w_ca;
                    w_b_d    = '0;
                    w_nxt_d  = bus.rd_data;
                    w_last_d = (r_i == ONE) && (r_j == '0);
                end else begin
                    w_op_d   = OP_INS;
                    w_a_d    = '0;
                    w_b_d    = w_cb;
                    w_nxt_d  = r_cur - W_INDEL;
                    w_last_d = (r_i == '0) && (r_j == ONE);
                end
                w_state_d = EMIT;
            end
            EMIT: begin
                if (bus.out_ready) begin
                    case (r_op)
                        OP_MATCH, OP_SUB: begin
                            w_si = r_i - 1'b1;
                            w_sj = r_j - 1'b1;
                        end
                        OP_DEL:  w_si = r_i - 1'b1;
                        default: w_sj = r_j - 1'b1;
                    endcase
                    w_i_d   = w_si;
                    w_j_d   = w_sj;
                    w_cur_d = r_nxt;
                    w_scur  = r_nxt;
                    w_step  = 1'b1;
                end
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase

        // Edge-of-matrix steps need no read, so they re-enter EMIT directly.
        if (w_step) begin
            if ((w_si == '0) && (w_sj == '0)) begin
                w_state_d = DONE;
            end else if (w_si == '0) begin
                w_op_d    = OP_INS;
                w_a_d     = '0;
                w_b_d     = char_at(r_s2, w_sj);
                w_nxt_d   = w_scur - W_INDEL;
                w_last_d  = (w_sj == ONE);
                w_state_d = EMIT;
            end else if (w_sj == '0) begin
                w_op_d    = OP_DEL;
                w_a_d     = char_at(r_s1, w_si);
                w_b_d     = '0;
                w_nxt_d   = w_scur - W_INDEL;
                w_last_d  = (w_si == ONE);
                w_state_d = EMIT;
            end else begin
                w_rd_row_d = w_si - 1'b1;
                w_rd_col_d = w_sj - 1'b1;
                w_state_d  = RD_DIAG;
            end
        end

        w_rd_en_d     = (w_state_d == RD_CUR) || (w_state_d == RD_DIAG) || (w_state_d == RD_UP);
        w_out_valid_d = (w_state_d == EMIT);
        w_busy_d      = (w_state_d != IDLE) && (w_state_d != DONE);
        w_done_d      = (w_state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_cur       <= '0;
            r_nxt       <= '0;
            r_final     <= '0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_op        <= OP_MATCH;
            r_a         <= '0;
            r_b         <= '0;
            r_last      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_row    <= '0;
            r_rd_col    <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_i         <= w_i_d;
            r_j         <= w_j_d;
            r_cur       <= w_cur_d;
            r_nxt       <= w_nxt_d;
            r_final     <= w_final_d;
            r_s1        <= w_s1_d;
            r_s2        <= w_s2_d;
            r_op        <= w_op_d;
            r_a         <= w_a_d;
            r_b         <= w_b_d;
            r_last      <= w_last_d;
            r_rd_en     <= w_rd_en_d;
            r_rd_row    <= w_rd_row_d;
            r_rd_col    <= w_rd_col_d;
            r_out_valid <= w_out_valid_d;
            r_busy      <= w_busy_d;
            r_done      <= w_done_d;
        end
    end

    assign bus.rd_en     = r_rd_en;
    assign bus.rd_row    = r_rd_row;
    assign bus.rd_col    = r_rd_col;
    assign bus.out_valid = r_out_valid;
    assign bus.out_op    = r_op;
    assign bus.out_a     = r_a;
    assign bus.out_b     = r_b;
    assign bus.out_last  = r_last;
    assign final_score   = r_final;
    assign busy          = r_busy;
    assign done          = r_done;
endmodule

// File: tb/tb_nw_traceback.sv
// Directed bench for nw_traceback: LENGTH=4 instance with a score RAM filled
// from the two strings, plus a LENGTH=1 instance for the minimal walk.
module tb_nw_traceback;
    typedef int ops_t [0:5];

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // LENGTH=4 instance
    logic               start4 = 1'b0;
    logic [7:0]         s1_4   = '0;
    logic [7:0]         s2_4   = '0;
    logic signed [15:0] final4;
    logic               busy4, done4;
    nw_traceback_if #(.CWIDTH(2), .SWIDTH(16), .IW(3)) bus4();
    nw_traceback #(
        .LENGTH(4), .CWIDTH(2), .SWIDTH(16),
        .MATCH(1), .INDEL(-1), .MISMATCH(-1), .IW(3)
    ) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .s1(s1_4), .s2(s2_4),
        .bus(bus4), .final_score(final4), .busy(busy4), .done(done4)
    );

    // LENGTH=1 instance
    logic               start1 = 1'b0;
    logic [1:0]         s1_1   = '0;
    logic [1:0]         s2_1   = '0;
    logic signed [15:0] final1;
    logic               busy1, done1;
    nw_traceback_if #(.CWIDTH(2), .SWIDTH(16), .IW(1)) bus1();
    nw_traceback #(
        .LENGTH(1), .CWIDTH(2), .SWIDTH(16),
        .MATCH(1), .INDEL(-1), .MISMATCH(-1), .IW(1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .s1(s1_1), .s2(s2_1),
        .bus(bus1), .final_score(final1), .busy(busy1), .done(done1)
    );

    // Score RAMs: one-cycle registered read
    logic signed [15:0] mem4 [0:7][0:7];
    logic signed [15:0] mem1 [0:1][0:1];
    always @(posedge clk) if (bus4.rd_en) bus4.rd_data <= mem4[bus4.rd_row][bus4.rd_col];
    always @(posedge clk) if (bus1.rd_en) bus1.rd_data <= mem1[bus1.rd_row][bus1.rd_col];

    int   rd_cnt4 = 0, rd_dbl4 = 0, done_cnt4 = 0;
    logic prev_rd4 = 1'b0;
    always @(posedge clk) begin
        if (bus4.rd_en) rd_cnt4++;
        if (bus4.rd_en && prev_rd4) rd_dbl4++;
        prev_rd4 = bus4.rd_en;
        if (done4) done_cnt4++;
    end

    int got [0:15];
    int n_ops, first_cyc, stable_bad;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // op*1000 + a*100 + b*10 + last
    function automatic int code4();
        return int'(bus4.out_op) * 1000 + int'(bus4.out_a) * 100 + int'(bus4.out_b) * 10 + int'(bus4.out_last);
    endfunction

    task automatic fill4(input logic [7:0] a, input logic [7:0] b);
        int h [0:4][0:4];
        int w, d, u, l;
        for (int i = 0; i <= 4; i++) h[i][0] = -i;
        for (int j = 0; j <= 4; j++) h[0][j] = -j;
        for (int i = 1; i <= 4; i++)
            for (int j = 1; j <= 4; j++) begin
                w = (a[(i-1)*2 +: 2] == b[(j-1)*2 +: 2]) ? 1 : -1;
                d = h[i-1][j-1] + w;
                u = h[i-1][j] - 1;
                l = h[i][j-1] - 1;
                h[i][j] = d;
                if (u > h[i][j]) h[i][j] = u;
                if (l > h[i][j]) h[i][j] = l;
            end
        for (int i = 0; i <= 4; i++)
            for (int j = 0; j <= 4; j++) mem4[i][j] = 16'(h[i][j]);
    endtask

    task automatic run4(input int stall, input int pulse_at);
        int cyc = 0;
        bit last_seen = 1'b0;
        int cur_code;
        n_ops = 0; first_cyc = -1; stable_bad = 0;
        for (int k = 0; k < 16; k++) got[k] = -1;
        @(negedge clk);
        rd_cnt4 = 0; rd_dbl4 = 0; done_cnt4 = 0;
        start4 = 1'b1;
        bus4.out_ready = (stall == 0);
        while (!last_seen && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start4 = 1'b0;
            if (pulse_at > 0 && cyc == pulse_at) start4 = 1'b1;
            if (pulse_at > 0 && cyc == pulse_at + 1) start4 = 1'b0;
            if (stall > 0) bus4.out_ready = 1'b0;
            if (bus4.out_valid) begin
                cur_code = code4();
                if (n_ops == 0) first_cyc = cyc;
                if (n_ops < 16) got[n_ops] = cur_code;
                n_ops++;
                last_seen = bus4.out_last;
                if (stall > 0) begin
                    repeat (stall) begin
                        @(negedge clk);
                        cyc++;
                        if (!bus4.out_valid || code4() != cur_code) stable_bad++;
                    end
                    bus4.out_ready = 1'b1;
                end
            end
        end
        chk("walk reaches out_last", last_seen, 1);
        @(negedge clk);
        chk("done after last op", done4, 1);
        chk("busy low with done", busy4, 0);
        repeat (3) @(negedge clk);
        chk("single done pulse", done_cnt4, 1);
        chk("idle out_valid", bus4.out_valid, 0);
    endtask

    task automatic cmp_ops(input string name, input int n, input ops_t e);
        chk({name, " op count"}, n_ops, n);
        for (int k = 0; k < n; k++) chk($sformatf("%s op%0d", name, k), got[k], e[k]);
    endtask

    initial begin
        int k;
        int extra;
        bus4.out_ready = 1'b1;
        bus1.out_ready = 1'b1;
        mem1[0][0] = 16'sd0;  mem1[0][1] = -16'sd1;
        mem1[1][0] = -16'sd1; mem1[1][1] = -16'sd1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst out_valid", bus4.out_valid, 0);
        chk("rst busy", busy4, 0);
        chk("rst done", done4, 0);
        chk("rst rd_en", bus4.rd_en, 0);
        chk("rst out_op", bus4.out_op, 0);
        chk("rst out_last", bus4.out_last, 0);
        chk("rst final_score", final4, 0);
        chk("rst rd_row", bus4.rd_row, 0);
        rst_n = 1'b1;

        // ACGT vs ACGT: four matches down the diagonal
        s1_4 = 8'hE4; s2_4 = 8'hE4; fill4(s1_4, s2_4);
        run4(0, 0);
        chk("t1 final_score", final4, 4);
        cmp_ops("t1", 4, '{330, 220, 110, 1, 0, 0});
        chk("t1 first valid", first_cyc, 5);
        chk("t1 reads", rd_cnt4, 5);
        chk("t1 rd_en single", rd_dbl4, 0);

        // AAAA vs CCCC: four substitutions
        s1_4 = 8'h00; s2_4 = 8'h55; fill4(s1_4, s2_4);
        run4(0, 0);
        chk("t2 final_score", final4, -4);
        cmp_ops("t2", 4, '{1010, 1010, 1010, 1011, 0, 0});
        chk("t2 reads", rd_cnt4, 5);

        // AAAC vs CAAA: DEL, three matches, boundary INS
        s1_4 = 8'h40; s2_4 = 8'h01; fill4(s1_4, s2_4);
        run4(0, 0);
        chk("t3 final_score", final4, 1);
        cmp_ops("t3", 5, '{2100, 0, 0, 0, 3011, 0});
        chk("t3 first valid", first_cyc, 7);
        chk("t3 reads", rd_cnt4, 6);

        // same walk with 10 stalled cycles per op
        run4(10, 0);
        cmp_ops("t4", 5, '{2100, 0, 0, 0, 3011, 0});
        chk("t4 stable under stall", stable_bad, 0);
        chk("t4 reads", rd_cnt4, 6);
        chk("t4 rd_en single", rd_dbl4, 0);

        // start pulsed mid-walk is ignored
        s1_4 = 8'hE4; s2_4 = 8'hE4; fill4(s1_4, s2_4);
        run4(0, 3);
        cmp_ops("t5", 4, '{330, 220, 110, 1, 0, 0});
        chk("t5 reads", rd_cnt4, 5);

        // reset while the first op is on the stream
        bus4.out_ready = 1'b0;
        @(negedge clk); start4 = 1'b1;
        @(negedge clk); start4 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t6 valid before reset", bus4.out_valid, 1);
        chk("t6 busy before reset", busy4, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 async out_valid", bus4.out_valid, 0);
        chk("t6 async busy", busy4, 0);
        chk("t6 async rd_en", bus4.rd_en, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus4.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6 no ops after reset", bus4.out_valid, 0);
        chk("t6 final cleared", final4, 0);

        // full walk after the abort
        s1_4 = 8'h40; s2_4 = 8'h01; fill4(s1_4, s2_4);
        run4(0, 0);
        chk("t7 final_score", final4, 1);
        cmp_ops("t7", 5, '{2100, 0, 0, 0, 3011, 0});

        // LENGTH=1, A vs C: one SUB that is also last
        s1_1 = 2'd0; s2_1 = 2'd1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        k = 0;
        while (!bus1.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t8 first valid", k, 4);
        chk("t8 op", bus1.out_op, 1);
        chk("t8 a", bus1.out_a, 0);
        chk("t8 b", bus1.out_b, 1);
        chk("t8 last", bus1.out_last, 1);
        chk("t8 final_score", final1, -1);
        @(negedge clk);
        chk("t8 done", done1, 1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus1.out_valid) extra++;
        end
        chk("t8 single op", extra, 0);
        chk("t8 idle busy", busy1, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
